// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned    XLEN             = 32;
  localparam logic [31:0]    NOP              = 32'h0000_0013;
  localparam logic [31:0]    DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, redirect input and decode-side instruction stream.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {inst, pc} entries with flush; DEPTH must be a power of two.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  fetch_entry_t                 data_i,
  output fetch_entry_t                 data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i & ~flush_i;
    do_pop   = pop_i & ~flush_i & ~empty_o;
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: in-order imem requests, response FIFO, redirect flush with stale-response drop.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam int unsigned DW      = $clog2(2 * DEPTH + 1);
  localparam int unsigned SW      = DW + 1;
  localparam int unsigned OUT_MAX = (1 << DW) - 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [DW-1:0]   drop_cnt_q, drop_cnt_d;

  logic            req_valid_c, accept_c, push_c, pop_c, flush_c;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    push_entry, head;

  assign push_entry = '{inst: bus.imem_resp_data, pc: resp_pc_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    resp_pc_d   = resp_pc_q;
    inflight_d  = inflight_q;
    drop_cnt_d  = drop_cnt_q;
    req_valid_c = 1'b0;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    flush_c     = 1'b0;

    // Total outstanding is also capped so drop_cnt cannot wrap under back-to-back redirects.
    case (state_q)
      BOOT: state_d = RUN;
      RUN:  req_valid_c = (SW'(fifo_count) + SW'(inflight_q) < SW'(DEPTH)) &&
                          (SW'(drop_cnt_q) + SW'(inflight_q) < SW'(OUT_MAX));
    endcase
    accept_c = req_valid_c & bus.imem_req_ready;

    if (bus.redirect_valid) begin
      pc_d       = bus.redirect_pc & ~XLEN'(3);
      resp_pc_d  = bus.redirect_pc & ~XLEN'(3);
      flush_c    = 1'b1;
      inflight_d = '0;
      drop_cnt_d = drop_cnt_q + DW'(inflight_q) + DW'(accept_c) - DW'(bus.imem_resp_valid);
    end else begin
      push_c     = bus.imem_resp_valid & (drop_cnt_q == '0);
      pop_c      = ~fifo_empty & bus.inst_ready;
      pc_d       = accept_c ? pc_q + XLEN'(4) : pc_q;
      resp_pc_d  = push_c ? resp_pc_q + XLEN'(4) : resp_pc_q;
      inflight_d = inflight_q + CW'(accept_c) - CW'(push_c);
      drop_cnt_d = drop_cnt_q - DW'(bus.imem_resp_valid & (drop_cnt_q != '0));
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .flush_i (flush_c),
    .data_i  (push_entry),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.imem_req_valid = req_valid_c;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = ~fifo_empty;
  assign bus.inst           = fifo_empty ? NOP : head.inst;
  assign bus.inst_pc        = fifo_empty ? '0 : head.pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push_c |-> (!fifo_full || pop_c));

  a_resp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_resp_valid |-> (inflight_q != '0 || drop_cnt_q != '0));

endmodule
